// File: rtl/rc4_prga_swap.sv
// rc4_prga_swap: RC4 keystream generation (PRGA) engine.
// Walks i, accumulates j, reads S[i] and S[j] from a synchronous-read S RAM,
// swaps them in place and presents the post-swap pair (s_i, s_j) while the RAM
// is released to the downstream decryption FSM.
// Optional build macro RC4_PRGA_ACK_TIMEOUT_EN adds a 256-cycle ack watchdog
// and the `timeout` output; without it AVAIL waits indefinitely for ack.
`timescale 1ns/1ps
module rc4_prga_swap #(
    parameter int MSG_DEP   = 32,
    parameter int MSG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MSG_WIDTH-1:0] s_data_in,
    input  logic                 keystream_ack,
    output logic [MSG_WIDTH-1:0] address_out,
    output logic [MSG_WIDTH-1:0] data_out,
    output logic                 wr_en,
    output logic [MSG_WIDTH-1:0] s_i,
    output logic [MSG_WIDTH-1:0] s_j,
    output logic                 s_j_available,
    output logic [MSG_WIDTH:0]   current_index,
`ifdef RC4_PRGA_ACK_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic                 done
);

    localparam logic [3:0] LP_IDLE    = 4'd0;
    localparam logic [3:0] LP_ADDR_I  = 4'd1;
    localparam logic [3:0] LP_WAIT_I  = 4'd2;
    localparam logic [3:0] LP_READ_I  = 4'd3;
    localparam logic [3:0] LP_ADDR_J  = 4'd4;
    localparam logic [3:0] LP_WAIT_J  = 4'd5;
    localparam logic [3:0] LP_READ_J  = 4'd6;
    localparam logic [3:0] LP_WRITE_I = 4'd7;
    localparam logic [3:0] LP_WRITE_J = 4'd8;
    localparam logic [3:0] LP_AVAIL   = 4'd9;
    localparam logic [3:0] LP_NEXT    = 4'd10;
    localparam logic [3:0] LP_DONE    = 4'd11;

    localparam logic [MSG_WIDTH-1:0] LP_ONE     = (MSG_WIDTH)'(1);
    localparam logic [MSG_WIDTH:0]   LP_IDX_ONE = (MSG_WIDTH+1)'(1);
    localparam logic [MSG_WIDTH:0]   LP_DEP     = (MSG_WIDTH+1)'(MSG_DEP);

    logic [3:0]           r_state;
    logic [MSG_WIDTH-1:0] r_i;
    logic [MSG_WIDTH-1:0] r_j;
    logic [MSG_WIDTH-1:0] r_ti;
    logic [MSG_WIDTH-1:0] r_tj;
    logic [MSG_WIDTH-1:0] r_address;
    logic [MSG_WIDTH-1:0] r_data;
    logic                 r_wr_en;
    logic [MSG_WIDTH-1:0] r_s_i;
    logic [MSG_WIDTH-1:0] r_s_j;
    logic                 r_avail;
    logic [MSG_WIDTH:0]   r_cur_idx;
    logic                 r_done;

    logic [MSG_WIDTH-1:0] w_i_inc;
    logic [MSG_WIDTH-1:0] w_j_sum;
    logic [MSG_WIDTH:0]   w_idx_inc;
    logic                 w_ack_expired;

    assign w_i_inc   = r_i + LP_ONE;
    assign w_j_sum   = r_j + s_data_in;
    assign w_idx_inc = r_cur_idx + LP_IDX_ONE;

`ifdef RC4_PRGA_ACK_TIMEOUT_EN
    logic [7:0] r_ack_cnt;
    logic       r_timeout;
    logic       w_start_ok;

    assign w_ack_expired = (r_ack_cnt == 8'hFF);
    assign w_start_ok    = start && ((r_state == LP_IDLE) || (r_state == LP_DONE));
    assign timeout       = r_timeout;

    // Count unacknowledged AVAIL cycles; flag expiry, clear the flag on a new start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            // Counter is zero on every AVAIL entry: it only runs inside AVAIL
            // and wraps to zero exactly on the expiry cycle that leaves AVAIL.
            if ((r_state == LP_AVAIL) && !keystream_ack)
                r_ack_cnt <= r_ack_cnt + 8'd1;
            else
                r_ack_cnt <= '0;
            if (w_start_ok)
                r_timeout <= 1'b0;
            else if ((r_state == LP_AVAIL) && !keystream_ack && w_ack_expired)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_ack_expired = 1'b0;
`endif

    // Main FSM: every output register is loaded with its value for the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= LP_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_ti      <= '0;
            r_tj      <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_wr_en   <= 1'b0;
            r_s_i     <= '0;
            r_s_j     <= '0;
            r_avail   <= 1'b0;
            r_cur_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                LP_IDLE: begin
                    if (start) begin
                        r_i       <= w_i_inc;
                        r_address <= w_i_inc;
                        r_state   <= LP_ADDR_I;
                    end
                end
                LP_ADDR_I: r_state <= LP_WAIT_I;
                LP_WAIT_I: r_state <= LP_READ_I;
                LP_READ_I: begin
                    r_ti      <= s_data_in;
                    r_j       <= w_j_sum;
                    r_address <= w_j_sum;
                    r_state   <= LP_ADDR_J;
                end
                LP_ADDR_J: r_state <= LP_WAIT_J;
                LP_WAIT_J: r_state <= LP_READ_J;
                LP_READ_J: begin
                    r_tj      <= s_data_in;
                    r_address <= r_i;
                    r_data    <= s_data_in;
                    r_wr_en   <= 1'b1;
                    r_state   <= LP_WRITE_I;
                end
                LP_WRITE_I: begin
                    r_address <= r_j;
                    r_data    <= r_ti;
                    r_state   <= LP_WRITE_J;
                end
                LP_WRITE_J: begin
                    r_wr_en <= 1'b0;
                    r_s_i   <= r_tj;
                    r_s_j   <= r_ti;
                    r_avail <= 1'b1;
                    r_state <= LP_AVAIL;
                end
                LP_AVAIL: begin
                    if (keystream_ack) begin
                        r_avail <= 1'b0;
                        r_state <= LP_NEXT;
                    end else if (w_ack_expired) begin
                        r_avail <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= LP_DONE;
                    end
                end
                LP_NEXT: begin
                    r_cur_idx <= w_idx_inc;
                    if (w_idx_inc == LP_DEP) begin
                        r_done  <= 1'b1;
                        r_state <= LP_DONE;
                    end else begin
                        r_i       <= w_i_inc;
                        r_address <= w_i_inc;
                        r_state   <= LP_ADDR_I;
                    end
                end
                LP_DONE: begin
                    // Restart keeps the S RAM contents but rewinds i/j
                    if (start) begin
                        r_i       <= LP_ONE;
                        r_j       <= '0;
                        r_cur_idx <= '0;
                        r_done    <= 1'b0;
                        r_address <= LP_ONE;
                        r_state   <= LP_ADDR_I;
                    end
                end
                default: r_state <= LP_IDLE;
            endcase
        end
    end

    assign address_out   = r_address;
    assign data_out      = r_data;
    assign wr_en         = r_wr_en;
    assign s_i           = r_s_i;
    assign s_j           = r_s_j;
    assign s_j_available = r_avail;
    assign current_index = r_cur_idx;
    assign done          = r_done;

endmodule

// File: tb/tb_rc4_prga_swap.sv
// tb_rc4_prga_swap: table vectors on an identity S RAM, mid-write reset,
// a 32-byte run against a software RC4 model, restart from DONE and the
// unacknowledged-AVAIL behaviour (watchdog when RC4_PRGA_ACK_TIMEOUT_EN is defined).
`timescale 1ns/1ps
module tb_rc4_prga_swap;
    localparam int W   = 8;
    localparam int DEP = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         keystream_ack = 1'b0;
    logic [W-1:0] s_data_in;
    logic [W-1:0] address_out, data_out, s_i, s_j;
    logic         wr_en, s_j_available, done;
    logic [W:0]   current_index;
`ifdef RC4_PRGA_ACK_TIMEOUT_EN
    logic         timeout;
`endif

    typedef struct { int wa0; int wd0; int wa1; int wd1; int si; int sj; int ks; } exp_t;
    typedef struct { int dly; bit stray; exp_t e; } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Software RC4 state
    int ms[256];
    int mi, mj;

    // Bench S RAM: synchronous read, consumer owns the address while s_j_available
    logic [7:0] ram [256];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = '0, load_data = '0;
    logic [7:0] ram_addr;
    assign ram_addr = s_j_available ? 8'(s_i + s_j) : address_out;

    always @(posedge clk) begin
        if (load_en)
            ram[load_addr] <= load_data;
        else if (wr_en)
            ram[address_out] <= data_out;
        s_data_in <= ram[ram_addr];
    end

    always #5 clk = ~clk;

    rc4_prga_swap #(.MSG_DEP(DEP), .MSG_WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .s_data_in     (s_data_in),
        .keystream_ack (keystream_ack),
        .address_out   (address_out),
        .data_out      (data_out),
        .wr_en         (wr_en),
        .s_i           (s_i),
        .s_j           (s_j),
        .s_j_available (s_j_available),
        .current_index (current_index),
`ifdef RC4_PRGA_ACK_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .done          (done)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_addr"}, address_out, 0);
        chk({nm, "_data"}, data_out, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_s_i"}, s_i, 0);
        chk({nm, "_s_j"}, s_j, 0);
        chk({nm, "_avail"}, s_j_available, 0);
        chk({nm, "_cur_idx"}, current_index, 0);
        chk({nm, "_done"}, done, 0);
`ifdef RC4_PRGA_ACK_TIMEOUT_EN
        chk({nm, "_timeout"}, timeout, 0);
`endif
    endtask

    task automatic model_step(output exp_t e);
        int t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        e.wa0 = mi; e.wd0 = ms[mj];
        e.wa1 = mj; e.wd1 = ms[mi];
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        e.si = ms[mi]; e.sj = ms[mj];
        e.ks = ms[(e.si + e.sj) % 256];
    endtask

    task automatic load_ram();
        load_en = 1'b1;
        for (int a = 0; a < 256; a++) begin
            load_addr = 8'(a);
            load_data = 8'(ms[a]);
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_avail(input string nm);
        int t = 0;
        while (!s_j_available && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_j_available) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait: s_j_available 0, expected 1 within 200 cycles", nm);
        end
    endtask

    // Called in the first AVAIL cycle; holds ack off for dly cycles, then acknowledges
    task automatic do_byte(input int dly, input string nm);
        int hi = 0, wr = 0, drift = 0;
        logic [W-1:0] si0, sj0;
        si0 = s_i; sj0 = s_j;
        for (int k = 0; k <= dly; k++) begin
            if (s_j_available) hi++;
            if (wr_en) wr++;
            if (s_i !== si0 || s_j !== sj0) drift++;
            if (k < dly) @(negedge clk);
        end
        keystream_ack = 1'b1;
        @(negedge clk);
        keystream_ack = 1'b0;
        chk({nm, "_avail_cycles"}, hi, dly + 1);
        chk({nm, "_wr_in_avail"}, wr, 0);
        chk({nm, "_pair_drift"}, drift, 0);
        chk({nm, "_avail_drop"}, s_j_available, 0);
        chk({nm, "_s_i_keep"}, s_i, si0);
        chk({nm, "_s_j_keep"}, s_j, sj0);
    endtask

    // Scoreboard monitor: collects the writes of each byte, checks them at AVAIL entry
    initial begin : monitor
        int   n_wr;
        int   wa[2];
        int   wd[2];
        bit   prev;
        exp_t e;
        n_wr = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_wr = 0; prev = 1'b0;
            end else begin
                if (wr_en) begin
                    if (n_wr < 2) begin
                        wa[n_wr] = address_out;
                        wd[n_wr] = data_out;
                    end
                    n_wr++;
                end
                if (s_j_available && !prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL sb_unexpected: got AVAIL with s_i=%0d s_j=%0d, expected none", s_i, s_j);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_wr_count", n_wr, 2);
                        chk("sb_wr_i_addr", wa[0], e.wa0);
                        chk("sb_wr_i_data", wd[0], e.wd0);
                        chk("sb_wr_j_addr", wa[1], e.wa1);
                        chk("sb_wr_j_data", wd[1], e.wd1);
                        chk("sb_s_i", s_i, e.si);
                        chk("sb_s_j", s_j, e.sj);
                        chk("sb_keystream", ram[8'(s_i + s_j)], e.ks);
                    end
                    n_wr = 0;
                end
                prev = s_j_available;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500 us, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t e;
        int   hi, wr, t;
        int   key[8];

        // Identity S: byte1 (1,1),(1,1); byte2 (2,3),(3,2); byte3 (3,5),(5,2); byte4 (4,9),(9,4)
        vecs[0] = '{0, 1'b1, '{1, 1, 1, 1, 1, 1, 2}};
        vecs[1] = '{5, 1'b0, '{2, 3, 3, 2, 3, 2, 5}};
        vecs[2] = '{0, 1'b1, '{3, 5, 5, 2, 5, 2, 7}};
        vecs[3] = '{3, 1'b0, '{4, 9, 9, 4, 9, 4, 13}};

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 256; a++) ms[a] = a;
        load_ram();

        // ack while IDLE does nothing
        keystream_ack = 1'b1;
        @(negedge clk);
        keystream_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ack_avail", s_j_available, 0);
        chk("idle_ack_addr", address_out, 0);

        // Table-driven bytes on identity S
        exp_q.push_back(vecs[0].e);
        pulse_start();
        chk("first_addr", address_out, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) exp_q.push_back(vecs[k].e);
            wait_avail("tbl");
            chk("tbl_cur_idx", current_index, k);
            do_byte(vecs[k].dly, "tbl");
            if (vecs[k].stray) begin
                keystream_ack = 1'b1;
                @(negedge clk);
                keystream_ack = 1'b0;
            end
        end

        // Byte 5 starts; reset during its WRITE_I abandons the write
        t = 0;
        while (!wr_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_found_write", wr_en, 1);
        reset = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("rst_post");
        chk("rst_queue_empty", exp_q.size(), 0);
        // S[1]=1 untouched, S[2]=3 from byte 2
        exp_q.push_back('{1, 1, 1, 1, 1, 1, 3});
        pulse_start();
        chk("rerun_addr", address_out, 1);
        wait_avail("rerun");
        do_byte(0, "rerun");

        // Full run after KSA with key bytes 00 00 00 00 00 00 00 01
        pulse_reset();
        for (int a = 0; a < 8; a++) key[a] = (a == 7) ? 1 : 0;
        for (int a = 0; a < 256; a++) ms[a] = a;
        mj = 0;
        for (int a = 0; a < 256; a++) begin
            mj = (mj + ms[a] + key[a % 8]) % 256;
            t = ms[a]; ms[a] = ms[mj]; ms[mj] = t;
        end
        load_ram();
        mi = 0; mj = 0;
        model_step(e);
        exp_q.push_back(e);
        pulse_start();
        chk("rc4_first_addr", address_out, 1);
        for (int k = 0; k < DEP; k++) begin
            if (k > 0) begin
                model_step(e);
                exp_q.push_back(e);
            end
            wait_avail("rc4");
            do_byte(int'($urandom_range(0, 2)), "rc4");
        end
        chk("rc4_done_in_next", done, 0);
        @(negedge clk);
        chk("rc4_done", done, 1);
        chk("rc4_cur_idx", current_index, DEP);
        repeat (3) @(negedge clk);
        chk("rc4_done_hold", done, 1);
        chk("rc4_cur_idx_hold", current_index, DEP);

        // Restart from DONE: i=1, j=0, S continues
        mi = 0; mj = 0;
        model_step(e);
        exp_q.push_back(e);
        pulse_start();
        chk("again_addr", address_out, 1);
        chk("again_cur_idx", current_index, 0);
        chk("again_done", done, 0);
        wait_avail("again");
        do_byte(1, "again");
        model_step(e);
        exp_q.push_back(e);
        wait_avail("again");
        do_byte(0, "again");

        // Withhold ack
        model_step(e);
        exp_q.push_back(e);
        wait_avail("noack");
`ifdef RC4_PRGA_ACK_TIMEOUT_EN
        hi = 0;
        while (s_j_available && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        chk("timeout_avail_cycles", hi, 256);
        chk("timeout_flag", timeout, 1);
        chk("timeout_done", done, 1);
        pulse_start();
        chk("timeout_clear", timeout, 0);
`else
        hi = 0; wr = 0;
        for (int k = 0; k < 1000; k++) begin
            if (s_j_available) hi++;
            if (wr_en) wr++;
            @(negedge clk);
        end
        chk("noack_avail_cycles", hi, 1000);
        chk("noack_wr", wr, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
